// File: rtl/core_dma_ctrl_pkg.sv
// Shared types and default addresses for the 2A03-style OAM/DMC DMA controller.
package core_dma_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE,
        HALT,
        ALIGN,
        GET,
        PUT,
        DMC_GET,
        DMC_PAD
    } dma_state_t;

    localparam logic [15:0] OAM_TRIG_DEF = 16'h4014;
    localparam logic [15:0] OAM_DEST_DEF = 16'h2004;
    localparam int          OAM_LEN_DEF  = 256;

endpackage

// File: rtl/core_dma_ctrl_if.sv
// CPU-side and external-bus-side signals of the DMA controller, bundled with master/slave views.
interface core_dma_ctrl_if
    import core_dma_ctrl_pkg::*;
#(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 8
);

    logic [ADDR_W-1:0] I_cpu_addr;
    logic [DATA_W-1:0] I_cpu_wr_data;
    logic              I_cpu_rdwr;
    logic [DATA_W-1:0] I_rd_data;
    logic              I_dmc_req;
    logic [ADDR_W-1:0] I_dmc_addr;
    logic              O_ready;
    logic [ADDR_W-1:0] O_addr;
    logic [DATA_W-1:0] O_wr_data;
    logic              O_rdwr;
    logic [DATA_W-1:0] O_dmc_data;
    logic              O_dmc_ack;

    modport slave (
        input  I_cpu_addr, I_cpu_wr_data, I_cpu_rdwr, I_rd_data, I_dmc_req, I_dmc_addr,
        output O_ready, O_addr, O_wr_data, O_rdwr, O_dmc_data, O_dmc_ack
    );

    modport master (
        output I_cpu_addr, I_cpu_wr_data, I_cpu_rdwr, I_rd_data, I_dmc_req, I_dmc_addr,
        input  O_ready, O_addr, O_wr_data, O_rdwr, O_dmc_data, O_dmc_ack
    );

endinterface

// File: rtl/core_dma_ctrl.sv
// Two-channel DMA controller (OAM page copy + DMC sample fetch) that halts the CPU and
// owns the bus during DMA cycles; outside DMA the CPU bus passes straight through.
module core_dma_ctrl
    import core_dma_ctrl_pkg::*;
#(
    parameter int                ADDR_W   = 16,
    parameter int                DATA_W   = 8,
    parameter logic [ADDR_W-1:0] OAM_TRIG = OAM_TRIG_DEF,
    parameter logic [ADDR_W-1:0] OAM_DEST = OAM_DEST_DEF,
    parameter int                OAM_LEN  = OAM_LEN_DEF,
    parameter bit                ALIGN_EN = 1'b1
) (
    input  logic           I_clock,
    input  logic           I_reset,
    input  logic           I_tick,
    core_dma_ctrl_if.slave bus
);

    localparam int CNT_W = $clog2(OAM_LEN + 1);

    dma_state_t        r_state;
    logic              r_parity;
    logic              r_pendOam;
    logic              r_pendDmc;
    logic [DATA_W-1:0] r_page;
    logic [7:0]        r_offs;
    logic [CNT_W-1:0]  r_count;
    logic [DATA_W-1:0] r_data;
    logic [ADDR_W-1:0] r_dmcAddr;
    logic [DATA_W-1:0] r_dmcData;
    logic              r_dmcAck;

    logic              w_trig;
    dma_state_t        w_nextGet;

    // Triggers are only honoured while the CPU is actually running its own write cycles.
    assign w_trig = (r_state == IDLE || r_state == HALT) && !r_pendOam &&
                    (bus.I_cpu_addr == OAM_TRIG) && !bus.I_cpu_rdwr;

    always_comb begin
        w_nextGet = IDLE;
        if (r_pendDmc)
            w_nextGet = DMC_GET;
        else if (r_pendOam)
            w_nextGet = GET;
    end

    always_ff @(posedge I_clock) begin
        if (I_reset) begin
            r_state   <= IDLE;
            r_parity  <= 1'b0;
            r_pendOam <= 1'b0;
            r_pendDmc <= 1'b0;
            r_page    <= '0;
            r_offs    <= '0;
            r_count   <= '0;
            r_data    <= '0;
            r_dmcAddr <= '0;
            r_dmcData <= '0;
            r_dmcAck  <= 1'b0;
        end else begin
            r_dmcAck <= 1'b0;
            if (I_tick) begin
                r_parity <= ~r_parity;
                if (bus.I_dmc_req && !r_pendDmc) begin
                    r_pendDmc <= 1'b1;
                    r_dmcAddr <= bus.I_dmc_addr;
                end
                if (w_trig) begin
                    r_pendOam <= 1'b1;
                    r_page    <= bus.I_cpu_wr_data;
                    r_offs    <= '0;
                end
                case (r_state)
                    IDLE: begin
                        if (r_pendOam || r_pendDmc)
                            r_state <= HALT;
                    end
                    // r_parity==0 here means the following cycle is a put, so one pad cycle is needed.
                    HALT: begin
                        if (bus.I_cpu_rdwr) begin
                            if (ALIGN_EN && !r_parity)
                                r_state <= ALIGN;
                            else
                                r_state <= w_nextGet;
                        end
                    end
                    ALIGN: r_state <= w_nextGet;
                    GET: begin
                        r_data  <= bus.I_rd_data;
                        r_state <= PUT;
                    end
                    PUT: begin
                        r_offs <= r_offs + 8'd1;
                        if (r_count == CNT_W'(OAM_LEN - 1)) begin
                            r_pendOam <= 1'b0;
                            r_count   <= '0;
                            r_state   <= r_pendDmc ? DMC_GET : IDLE;
                        end else begin
                            r_count <= r_count + 1'b1;
                            r_state <= w_nextGet;
                        end
                    end
                    DMC_GET: begin
                        r_dmcData <= bus.I_rd_data;
                        r_dmcAck  <= 1'b1;
                        r_pendDmc <= 1'b0;
                        r_state   <= r_pendOam ? DMC_PAD : IDLE;
                    end
                    DMC_PAD: r_state <= GET;
                    default: r_state <= IDLE;
                endcase
            end
        end
    end

    // Dummy cycles (HALT/ALIGN/DMC_PAD) re-issue the CPU address as a read.
    always_comb begin
        bus.O_addr    = bus.I_cpu_addr;
        bus.O_wr_data = bus.I_cpu_wr_data;
        bus.O_rdwr    = 1'b1;
        case (r_state)
            IDLE:    bus.O_rdwr = bus.I_cpu_rdwr;
            GET:     bus.O_addr = ADDR_W'({r_page, r_offs});
            PUT: begin
                bus.O_addr    = OAM_DEST;
                bus.O_wr_data = r_data;
                bus.O_rdwr    = 1'b0;
            end
            DMC_GET: bus.O_addr = r_dmcAddr;
            default: ;
        endcase
    end

    assign bus.O_ready    = (r_state == IDLE);
    assign bus.O_dmc_data = r_dmcData;
    assign bus.O_dmc_ack  = r_dmcAck;

endmodule

// File: tb/tb_core_dma_ctrl.sv
// Directed bench for core_dma_ctrl: OAM copies at both parities, RMW halt, DMC preemption,
// idle DMC fetches and reset mid-transfer, with a small memory model behind the bus.
module tb_core_dma_ctrl;

    localparam int          EV_DUMMY      = 0;
    localparam int          EV_GET        = 1;
    localparam int          EV_PUT        = 2;
    localparam int          EV_DMC        = 3;
    localparam logic [15:0] CPU_IDLE_ADDR = 16'h8000;
    localparam logic [15:0] NO_DMC_ADDR   = 16'hFFFF;

    logic I_clock = 1'b0;
    logic I_reset;
    logic I_tick;

    int total = 0;
    int bad = 0;
    int benchParity = 0;
    int ackHigh = 0;
    int lowCycles, dummyCnt, getCnt, putCnt, dmcCnt, writeCnt;
    int getErrs, putErrs, getsAtDmc, putsAtDmc;
    bit watchDone;
    int evtKind[$];
    logic [15:0] evtAddr[$];

    core_dma_ctrl_if #(.ADDR_W(16), .DATA_W(8)) bus ();

    core_dma_ctrl #(
        .ADDR_W(16), .DATA_W(8), .OAM_TRIG(16'h4014), .OAM_DEST(16'h2004),
        .OAM_LEN(256), .ALIGN_EN(1'b1)
    ) dut (
        .I_clock(I_clock),
        .I_reset(I_reset),
        .I_tick (I_tick),
        .bus    (bus)
    );

    always #5 I_clock = ~I_clock;

    function automatic logic [7:0] memByte(input logic [15:0] a);
        if (a == 16'hC400)
            return 8'h5A;
        return a[7:0] ^ a[15:8] ^ 8'h3C;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic [15:0] addr, input logic [7:0] wdata, input logic rdwr);
        bus.I_cpu_addr    = addr;
        bus.I_cpu_wr_data = wdata;
        bus.I_cpu_rdwr    = rdwr;
    endtask

    // One CPU cycle: a tick clock followed by a non-tick clock.
    task automatic tickCycle();
        #1;
        bus.I_rd_data = memByte(bus.O_addr);
        I_tick = 1'b1;
        @(posedge I_clock);
        #1;
        I_tick = 1'b0;
        if (bus.O_dmc_ack) ackHigh++;
        @(posedge I_clock);
        #1;
        if (bus.O_dmc_ack) ackHigh++;
        benchParity ^= 1;
    endtask

    task automatic cpuWrite(input logic [15:0] addr, input logic [7:0] data);
        applyStimulus(addr, data, 1'b0);
        tickCycle();
        applyStimulus(CPU_IDLE_ADDR, 8'h00, 1'b1);
    endtask

    task automatic alignParity(input int p);
        while (benchParity != p) begin
            applyStimulus(CPU_IDLE_ADDR, 8'h00, 1'b1);
            tickCycle();
        end
    endtask

    task automatic dmcRequest(input logic [15:0] addr);
        bus.I_dmc_req  = 1'b1;
        bus.I_dmc_addr = addr;
        tickCycle();
        bus.I_dmc_req  = 1'b0;
    endtask

    // Runs CPU cycles until the CPU has been halted and released again, classifying each halted cycle.
    task automatic watchDma(input logic [7:0] page, input int writesInHalt, input int dmcAtGet,
                            input logic [15:0] dmcAddr, input int stopAtPut);
        int  budget;
        bit  seenLow;
        int  wleft;
        budget = 800; seenLow = 0; wleft = writesInHalt;
        lowCycles = 0; dummyCnt = 0; getCnt = 0; putCnt = 0; dmcCnt = 0; writeCnt = 0;
        getErrs = 0; putErrs = 0; getsAtDmc = -1; putsAtDmc = -1; ackHigh = 0; watchDone = 0;
        evtKind.delete();
        evtAddr.delete();
        while (budget > 0) begin
            budget--;
            if (bus.O_ready) begin
                if (seenLow) begin
                    watchDone = 1;
                    break;
                end
                applyStimulus(CPU_IDLE_ADDR, 8'h00, 1'b1);
                #1;
            end else begin
                seenLow = 1;
                lowCycles++;
                if (wleft > 0) begin
                    applyStimulus(CPU_IDLE_ADDR, 8'hEE, 1'b0);
                    wleft--;
                end else begin
                    applyStimulus(CPU_IDLE_ADDR, 8'h00, 1'b1);
                end
                #1;
                if (!bus.O_rdwr) begin
                    writeCnt++;
                    if (bus.O_addr !== 16'h2004 || bus.O_wr_data !== memByte({page, putCnt[7:0]}))
                        putErrs++;
                    evtKind.push_back(EV_PUT);
                    evtAddr.push_back(bus.O_addr);
                    putCnt++;
                    if (putCnt - 1 == stopAtPut) begin
                        watchDone = 1;
                        break;
                    end
                end else if (bus.O_addr == CPU_IDLE_ADDR) begin
                    dummyCnt++;
                    evtKind.push_back(EV_DUMMY);
                    evtAddr.push_back(bus.O_addr);
                end else if (bus.O_addr == dmcAddr) begin
                    dmcCnt++;
                    getsAtDmc = getCnt;
                    putsAtDmc = putCnt;
                    evtKind.push_back(EV_DMC);
                    evtAddr.push_back(bus.O_addr);
                end else begin
                    if (bus.O_addr !== {page, getCnt[7:0]})
                        getErrs++;
                    if (getCnt == dmcAtGet) begin
                        bus.I_dmc_req  = 1'b1;
                        bus.I_dmc_addr = dmcAddr;
                    end
                    evtKind.push_back(EV_GET);
                    evtAddr.push_back(bus.O_addr);
                    getCnt++;
                end
            end
            tickCycle();
            bus.I_dmc_req = 1'b0;
        end
        checkOutput("watchDone", 32'(watchDone), 32'd1);
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int lowSeen;
        int wrSeen;
        I_tick = 1'b0;
        I_reset = 1'b1;
        applyStimulus(CPU_IDLE_ADDR, 8'h00, 1'b1);
        bus.I_rd_data = 8'h00;
        bus.I_dmc_req = 1'b0;
        bus.I_dmc_addr = 16'h0000;
        repeat (2) @(posedge I_clock);
        #1;
        I_reset = 1'b0;
        benchParity = 0;

        applyStimulus(16'h1234, 8'h77, 1'b0);
        #1;
        checkOutput("rst_ready", 32'(bus.O_ready), 32'd1);
        checkOutput("rst_addr", 32'(bus.O_addr), 32'h1234);
        checkOutput("rst_wrdata", 32'(bus.O_wr_data), 32'h77);
        checkOutput("rst_rdwr", 32'(bus.O_rdwr), 32'd0);
        checkOutput("rst_ack", 32'(bus.O_dmc_ack), 32'd0);
        checkOutput("rst_dmcdata", 32'(bus.O_dmc_data), 32'h00);
        applyStimulus(CPU_IDLE_ADDR, 8'h00, 1'b1);

        // OAM page 0x02, halt tick on parity 0: no alignment cycle.
        alignParity(1);
        cpuWrite(16'h4014, 8'h02);
        #1;
        checkOutput("A_pendReady", 32'(bus.O_ready), 32'd1);
        watchDma(8'h02, 0, -1, NO_DMC_ADDR, -1);
        checkOutput("A_lowCycles", 32'(lowCycles), 32'd513);
        checkOutput("A_dummies", 32'(dummyCnt), 32'd1);
        checkOutput("A_gets", 32'(getCnt), 32'd256);
        checkOutput("A_puts", 32'(putCnt), 32'd256);
        checkOutput("A_getErrs", 32'(getErrs), 32'd0);
        checkOutput("A_putErrs", 32'(putErrs), 32'd0);
        checkOutput("A_firstGet", 32'(evtAddr[1]), 32'h0200);
        applyStimulus(16'h4567, 8'h99, 1'b0);
        #1;
        checkOutput("A_passAddr", 32'(bus.O_addr), 32'h4567);
        checkOutput("A_passRdwr", 32'(bus.O_rdwr), 32'd0);
        applyStimulus(CPU_IDLE_ADDR, 8'h00, 1'b1);

        // OAM page 0x03, halt tick on parity 1: one ALIGN dummy read.
        alignParity(0);
        cpuWrite(16'h4014, 8'h03);
        watchDma(8'h03, 0, -1, NO_DMC_ADDR, -1);
        checkOutput("B_lowCycles", 32'(lowCycles), 32'd514);
        checkOutput("B_dummies", 32'(dummyCnt), 32'd2);
        checkOutput("B_alignEvt", 32'(evtKind[1]), 32'(EV_DUMMY));
        checkOutput("B_firstGet", 32'(evtAddr[2]), 32'h0300);
        checkOutput("B_getErrs", 32'(getErrs), 32'd0);
        checkOutput("B_putErrs", 32'(putErrs), 32'd0);
        checkOutput("B_puts", 32'(putCnt), 32'd256);

        // CPU write cycles during HALT hold the halt without DMA writes.
        alignParity(1);
        cpuWrite(16'h4014, 8'h04);
        watchDma(8'h04, 2, -1, NO_DMC_ADDR, -1);
        checkOutput("C_lowCycles", 32'(lowCycles), 32'd515);
        checkOutput("C_dummies", 32'(dummyCnt), 32'd3);
        checkOutput("C_busWrites", 32'(writeCnt), 32'd256);
        checkOutput("C_putErrs", 32'(putErrs), 32'd0);
        checkOutput("C_thirdHalt", 32'(evtKind[2]), 32'(EV_DUMMY));
        checkOutput("C_firstGet", 32'(evtAddr[3]), 32'h0400);

        // DMC fetch preempts OAM after put 0x10, then a pad cycle and resume at 0x0211.
        alignParity(1);
        cpuWrite(16'h4014, 8'h02);
        watchDma(8'h02, 0, 16, 16'hC123, -1);
        checkOutput("D_lowCycles", 32'(lowCycles), 32'd515);
        checkOutput("D_dmcReads", 32'(dmcCnt), 32'd1);
        checkOutput("D_getsBefore", 32'(getsAtDmc), 32'd17);
        checkOutput("D_putsBefore", 32'(putsAtDmc), 32'd17);
        checkOutput("D_prevPut", 32'(evtAddr[34]), 32'h2004);
        checkOutput("D_dmcEvt", 32'(evtAddr[35]), 32'hC123);
        checkOutput("D_padEvt", 32'(evtKind[36]), 32'(EV_DUMMY));
        checkOutput("D_resumeGet", 32'(evtAddr[37]), 32'h0211);
        checkOutput("D_ackClocks", 32'(ackHigh), 32'd1);
        checkOutput("D_dmcData", 32'(bus.O_dmc_data), 32'hDE);
        checkOutput("D_getErrs", 32'(getErrs), 32'd0);
        checkOutput("D_putErrs", 32'(putErrs), 32'd0);
        checkOutput("D_dummies", 32'(dummyCnt), 32'd2);

        // Idle DMC request, halt on get-aligned parity: no ALIGN.
        alignParity(1);
        dmcRequest(16'hC400);
        watchDma(8'h00, 0, -1, 16'hC400, -1);
        checkOutput("E1_lowCycles", 32'(lowCycles), 32'd2);
        checkOutput("E1_dummies", 32'(dummyCnt), 32'd1);
        checkOutput("E1_dmcReads", 32'(dmcCnt), 32'd1);
        checkOutput("E1_gets", 32'(getCnt), 32'd0);
        checkOutput("E1_ackClocks", 32'(ackHigh), 32'd1);
        checkOutput("E1_dmcData", 32'(bus.O_dmc_data), 32'h5A);
        checkOutput("E1_ready", 32'(bus.O_ready), 32'd1);

        // Idle DMC request, halt on put-aligned parity: one ALIGN.
        alignParity(0);
        dmcRequest(16'h1234);
        watchDma(8'h00, 0, -1, 16'h1234, -1);
        checkOutput("E2_lowCycles", 32'(lowCycles), 32'd3);
        checkOutput("E2_dummies", 32'(dummyCnt), 32'd2);
        checkOutput("E2_ackClocks", 32'(ackHigh), 32'd1);
        checkOutput("E2_dmcData", 32'(bus.O_dmc_data), 32'h1A);

        // Reset during the put of byte 0x40.
        alignParity(1);
        cpuWrite(16'h4014, 8'h05);
        watchDma(8'h05, 0, -1, NO_DMC_ADDR, 8'h40);
        checkOutput("F_stopPut", 32'(bus.O_addr), 32'h2004);
        I_reset = 1'b1;
        applyStimulus(CPU_IDLE_ADDR, 8'h00, 1'b1);
        @(posedge I_clock);
        #1;
        I_reset = 1'b0;
        benchParity = 0;
        #1;
        checkOutput("F_ready", 32'(bus.O_ready), 32'd1);
        checkOutput("F_addr", 32'(bus.O_addr), 32'(CPU_IDLE_ADDR));
        checkOutput("F_rdwr", 32'(bus.O_rdwr), 32'd1);
        checkOutput("F_ack", 32'(bus.O_dmc_ack), 32'd0);
        checkOutput("F_dmcData", 32'(bus.O_dmc_data), 32'h00);
        lowSeen = 0;
        wrSeen = 0;
        for (int i = 0; i < 20; i++) begin
            applyStimulus(CPU_IDLE_ADDR, 8'h00, 1'b1);
            #1;
            if (!bus.O_ready) lowSeen++;
            if (!bus.O_rdwr) wrSeen++;
            tickCycle();
        end
        checkOutput("F_noHalt", 32'(lowSeen), 32'd0);
        checkOutput("F_noWrites", 32'(wrSeen), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
